// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map, TCON bit positions and decode helper for the reload timer
package timer_pkg;

    // Default base of the timer window on the data-memory bus.
    localparam logic [31:0] TIMER_BASE = 32'h4000_0000;

    // Byte offsets of the registers inside the window.
    localparam logic [31:0] TH_OFF   = 32'h0000_0000;
    localparam logic [31:0] TL_OFF   = 32'h0000_0004;
    localparam logic [31:0] TCON_OFF = 32'h0000_0008;

    // TCON bit positions.
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    // Which register (if any) an access targets.
    typedef enum logic [1:0] {
        REG_TH   = 2'd0,
        REG_TL   = 2'd1,
        REG_TCON = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_e;

    // Word-address decode: byte-lane bits are ignored on both sides.
    function automatic reg_sel_e reg_decode(input logic [31:0] base, input logic [29:0] word);
        logic [31:0] th_a;
        logic [31:0] tl_a;
        logic [31:0] tc_a;
        reg_sel_e    sel;
        th_a = base + TH_OFF;
        tl_a = base + TL_OFF;
        tc_a = base + TCON_OFF;
        sel  = REG_NONE;
        if (word == th_a[31:2]) begin
            sel = REG_TH;
        end else if (word == tl_a[31:2]) begin
            sel = REG_TL;
        end else if (word == tc_a[31:2]) begin
            sel = REG_TCON;
        end
        return sel;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running divide-by-PRESCALE tick generator with hold on disable
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    // A one-bit counter is kept even for PRESCALE=1 so the port widths stay legal;
    // it simply never leaves zero in that case.
    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last phase so the counter wraps to 0 on the same edge that consumes it.
    assign tick = en && (cnt_q == LAST);

    // Next phase: advance while enabled, freeze (keep phase) while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - memory-mapped 32-bit reload timer driving the IRQ level
module timer_irq
    import timer_pkg::*;
#(
    parameter int          PRESCALE = 1,
    parameter logic [31:0] BASE     = TIMER_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] rdata,
    output logic        IRQ
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;

    reg_sel_e    sel;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        tick;
    logic        overflow;
    logic        unused_addr_lanes;

    // Byte-lane bits never take part in decode.
    assign unused_addr_lanes = ^addr[1:0];

    assign sel     = reg_decode(BASE, addr[31:2]);
    assign wr_th   = MemWr && (sel == REG_TH);
    assign wr_tl   = MemWr && (sel == REG_TL);
    assign wr_tcon = MemWr && (sel == REG_TCON);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .tick  (tick)
    );

    assign overflow = tick && (tl_q == 32'hFFFF_FFFF);

    // Next-state with same-cycle priorities: a TL write wins over counting, a reload
    // uses the TH held before this edge, and an overflow set of ST cannot be undone
    // by a simultaneous TCON write so no interrupt is lost.
    always_comb begin
        th_d = th_q;
        tl_d = tl_q;
        en_d = en_q;
        ie_d = ie_q;
        st_d = st_q;

        if (wr_th) begin
            th_d = wdata;
        end

        if (wr_tl) begin
            tl_d = wdata;
        end else if (overflow) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        if (wr_tcon) begin
            en_d = wdata[TCON_EN];
            ie_d = wdata[TCON_IE];
            st_d = wdata[TCON_ST];
        end

        if (overflow && ie_q) begin
            st_d = 1'b1;
        end
    end

    // Register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q <= '0;
            tl_q <= '0;
            en_q <= 1'b0;
            ie_q <= 1'b0;
            st_q <= 1'b0;
        end else begin
            th_q <= th_d;
            tl_q <= tl_d;
            en_q <= en_d;
            ie_q <= ie_d;
            st_q <= st_d;
        end
    end

    // Read mux returns pre-write contents, so a combined read/write sees the old value.
    always_comb begin
        rdata = '0;
        if (MemRd) begin
            case (sel)
                REG_TH:   rdata = th_q;
                REG_TL:   rdata = tl_q;
                REG_TCON: rdata = {29'd0, st_q, ie_q, en_q};
                default:  rdata = '0;
            endcase
        end
    end

    // Level interrupt straight from the stored enable and status bits.
    assign IRQ = ie_q & st_q;

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - self-checking bench for timer_irq with PRESCALE=1 and PRESCALE=4 instances
module tb_timer_irq;

    localparam logic [31:0] B = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        MemRd = 1'b0;
    logic        MemWr = 1'b0;
    logic [31:0] rdata1, rdata4;
    logic        irq1, irq4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_irq #(.PRESCALE(1), .BASE(B)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemRd(MemRd), .MemWr(MemWr), .rdata(rdata1), .IRQ(irq1)
    );

    timer_irq #(.PRESCALE(4), .BASE(B)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemRd(MemRd), .MemWr(MemWr), .rdata(rdata4), .IRQ(irq4)
    );

    // Reference model: index 0 is the PRESCALE=1 instance, 1 is PRESCALE=4.
    logic [31:0] m_th [2];
    logic [31:0] m_tl [2];
    logic        m_en [2];
    logic        m_ie [2];
    logic        m_st [2];
    int          m_ph [2];
    int          m_p  [2] = '{1, 4};

    function automatic int m_sel(input logic [31:0] a);
        logic [31:0] off;
        off = (a - B) & 32'hFFFF_FFFC;
        if (off < 32'd12) return int'(off >> 2);
        return 3;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [31:0] a, input logic rd);
        if (!rd) return 32'd0;
        case (m_sel(a))
            0: return m_th[k];
            1: return m_tl[k];
            2: return {29'd0, m_st[k], m_ie[k], m_en[k]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_th[k] = 0; m_tl[k] = 0; m_en[k] = 0; m_ie[k] = 0; m_st[k] = 0; m_ph[k] = 0;
        end
    endtask

    task automatic m_step(input logic [31:0] a, input logic [31:0] d, input logic wr);
        int  s;
        logic tk, ov, old_ie;
        s = m_sel(a);
        for (int k = 0; k < 2; k++) begin
            tk = m_en[k] && (m_ph[k] == m_p[k] - 1);
            if (m_en[k]) m_ph[k] = (m_ph[k] + 1) % m_p[k];
            ov = tk && (m_tl[k] == 32'hFFFF_FFFF);
            old_ie = m_ie[k];
            if (wr && s == 1) m_tl[k] = d;
            else if (ov) m_tl[k] = m_th[k];
            else if (tk) m_tl[k] = m_tl[k] + 32'd1;
            if (wr && s == 0) m_th[k] = d;
            if (wr && s == 2) begin
                m_en[k] = d[0]; m_ie[k] = d[1]; m_st[k] = d[2];
            end
            if (ov && old_ie) m_st[k] = 1'b1;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
        addr = a; wdata = d; MemRd = rd; MemWr = wr;
    endtask

    // One rising edge; model advances with the bus values seen at that edge.
    task automatic step();
        @(posedge clk);
        if (!reset) m_step(addr, wdata, MemWr);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, d, 1'b0, 1'b1);
        step();
        drive(32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_zero;
        exp_zero = 32'd0;
        apply_reset();
        drive(32'd0, 32'd0, 1'b0, 1'b0); #2;
        checks++; if (rdata1 !== exp_zero) begin failures++; $display("FAIL reset_rdata_idle got=%h exp=%h", rdata1, exp_zero); end
        checks++; if (irq1 !== 1'b0 || irq4 !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b/%b exp=0", irq1, irq4); end
        for (int r = 0; r < 3; r++) begin
            drive(B + 32'(r * 4), 32'd0, 1'b1, 1'b0); #2;
            checks++; if (rdata1 !== exp_zero || rdata4 !== exp_zero) begin failures++; $display("FAIL reset_reg%0d got=%h/%h exp=%h", r, rdata1, rdata4, exp_zero); end
        end
        // Asynchronous reset mid-count, then counting stays off until EN is written.
        wr(B + 32'd4, 32'd5);
        wr(B + 32'd8, 32'd1);
        step(); step();
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0); #2;
        reset = 1'b1; m_reset(); #1;
        checks++; if (rdata1 !== exp_zero) begin failures++; $display("FAIL reset_async_tl got=%h exp=%h", rdata1, exp_zero); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step(); step(); step(); #1;
        checks++; if (rdata1 !== exp_zero) begin failures++; $display("FAIL reset_no_resume got=%h exp=%h", rdata1, exp_zero); end
    endtask

    task automatic test_overflow();
        apply_reset();
        wr(B + 32'd0, 32'hFFFF_FFF0);
        wr(B + 32'd4, 32'hFFFF_FFFE);
        wr(B + 32'd8, 32'd3);
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0);
        step(); #1;
        checks++; if (rdata1 !== 32'hFFFF_FFFF || irq1 !== 1'b0) begin failures++; $display("FAIL ovf_first_tick tl=%h irq=%b exp tl=ffffffff irq=0", rdata1, irq1); end
        step(); #1;
        checks++; if (rdata1 !== 32'hFFFF_FFF0) begin failures++; $display("FAIL ovf_reload got=%h exp=fffffff0", rdata1); end
        checks++; if (irq1 !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b exp=1", irq1); end
        drive(B + 32'd8, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'd7) begin failures++; $display("FAIL ovf_tcon got=%h exp=7", rdata1); end
    endtask

    task automatic test_clear_noie();
        apply_reset();
        wr(B + 32'd0, 32'h10);
        wr(B + 32'd8, 32'd6);
        #1;
        checks++; if (irq1 !== 1'b1) begin failures++; $display("FAIL st_set_by_write irq=%b exp=1", irq1); end
        wr(B + 32'd8, 32'd3);
        #1;
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL st_clear irq=%b exp=0", irq1); end
        wr(B + 32'd8, 32'd1);
        wr(B + 32'd4, 32'hFFFF_FFFD);
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'hFFFF_FFFD) begin failures++; $display("FAIL tl_write_beats_tick got=%h exp=fffffffd", rdata1); end
        step(); step(); step(); #1;
        checks++; if (rdata1 !== 32'h10 || irq1 !== 1'b0) begin failures++; $display("FAIL noie_reload tl=%h irq=%b exp tl=10 irq=0", rdata1, irq1); end
        drive(B + 32'd8, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'd1) begin failures++; $display("FAIL noie_tcon got=%h exp=1", rdata1); end
    endtask

    task automatic test_collision();
        apply_reset();
        wr(B + 32'd0, 32'h55);
        wr(B + 32'd4, 32'hFFFF_FFFF);
        wr(B + 32'd8, 32'd3);
        wr(B + 32'd8, 32'd2);
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'h55) begin failures++; $display("FAIL coll_tl got=%h exp=55", rdata1); end
        drive(B + 32'd8, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'd6 || irq1 !== 1'b1) begin failures++; $display("FAIL coll_st_kept tcon=%h irq=%b exp tcon=6 irq=1", rdata1, irq1); end
        wr(B + 32'd0, 32'hA);
        wr(B + 32'd4, 32'hFFFF_FFFF);
        wr(B + 32'd8, 32'd1);
        wr(B + 32'd0, 32'hB);
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'hA) begin failures++; $display("FAIL coll_old_th got=%h exp=a", rdata1); end
        wr(B + 32'd4, 32'h1234);
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'h1234) begin failures++; $display("FAIL coll_tl_write got=%h exp=1234", rdata1); end
        drive(B + 32'd0, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'hB) begin failures++; $display("FAIL coll_new_th got=%h exp=b", rdata1); end
    endtask

    task automatic test_prescaler();
        apply_reset();
        wr(B + 32'd8, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            drive(B + 32'd4, 32'd0, 1'b1, 1'b0);
            step(); #1;
            if (k == 3 || k == 4 || k == 8 || k == 10) begin
                checks++; if (rdata4 !== 32'(k / 4)) begin failures++; $display("FAIL pre_edge%0d got=%h exp=%h", k, rdata4, 32'(k / 4)); end
            end
        end
        wr(B + 32'd8, 32'd0);
        repeat (5) step();
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata4 !== 32'd2) begin failures++; $display("FAIL pre_frozen got=%h exp=2", rdata4); end
        wr(B + 32'd8, 32'd1);
        drive(B + 32'd4, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata4 !== 32'd2) begin failures++; $display("FAIL pre_reenable got=%h exp=2", rdata4); end
        step(); #1;
        checks++; if (rdata4 !== 32'd3) begin failures++; $display("FAIL pre_phase_held got=%h exp=3", rdata4); end
    endtask

    task automatic test_decode();
        logic [31:0] probe [4];
        probe = '{B + 32'hC, B - 32'd4, B + 32'h10, B + 32'hFFC};
        apply_reset();
        wr(B + 32'd0, 32'h1111_2222);
        wr(B + 32'd4, 32'h33);
        wr(B + 32'd8, 32'hFFFF_FFFA);
        for (int i = 0; i < 4; i++) begin
            drive(probe[i], 32'd0, 1'b1, 1'b0); #1;
            checks++; if (rdata1 !== 32'd0) begin failures++; $display("FAIL dec_miss_%0d got=%h exp=0", i, rdata1); end
        end
        wr(B + 32'h10, 32'hFFFF_FFFF);
        wr(B - 32'd4, 32'hFFFF_FFFF);
        drive(B + 32'd0, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'h1111_2222) begin failures++; $display("FAIL dec_th got=%h exp=11112222", rdata1); end
        drive(B + 32'd7, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'h33) begin failures++; $display("FAIL dec_tl_lanes got=%h exp=33", rdata1); end
        drive(B + 32'd8, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'd2) begin failures++; $display("FAIL dec_tcon got=%h exp=2", rdata1); end
        drive(B + 32'd2, 32'd0, 1'b1, 1'b0); #1;
        checks++; if (rdata1 !== 32'h1111_2222) begin failures++; $display("FAIL dec_th_lanes got=%h exp=11112222", rdata1); end
        drive(B + 32'd0, 32'd0, 1'b0, 1'b0); #1;
        checks++; if (rdata1 !== 32'd0) begin failures++; $display("FAIL dec_no_strobe got=%h exp=0", rdata1); end
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        logic [31:0] a, d, e1, e4;
        logic        rd, w;
        int          bad;
        addrs = '{B, B + 32'd4, B + 32'd8, B + 32'hC, B - 32'd4, B + 32'd1, B + 32'd6, B + 32'hB};
        bad = 0;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) apply_reset();
            a  = addrs[$urandom_range(0, 7)];
            rd = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 2) == 0);
            case (m_sel(a))
                1: d = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                2: d = {$urandom, 3'b000} | 32'($urandom_range(0, 7));
                default: d = $urandom;
            endcase
            drive(a, d, rd, w); #2;
            e1 = m_read(0, a, rd);
            e4 = m_read(1, a, rd);
            checks++;
            if (rdata1 !== e1 || rdata4 !== e4 || irq1 !== (m_ie[0] & m_st[0]) || irq4 !== (m_ie[1] & m_st[1])) begin
                failures++;
                if (bad < 10) $display("FAIL rand_%0d a=%h rd1=%h/%h rd4=%h/%h irq=%b%b/%b%b (got/exp)",
                    i, a, rdata1, e1, rdata4, e4, irq1, (m_ie[0] & m_st[0]), irq4, (m_ie[1] & m_st[1]));
                bad++;
            end
            step();
        end
        drive(32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        m_reset();
        test_reset();
        test_overflow();
        test_clear_noie();
        test_collision();
        test_prescaler();
        test_decode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped 32-bit reload timer that generates the `IRQ` level consumed by the instruction decoder/control unit. It sits on the data-memory bus beside data RAM and is accessed by `lw`/`sw` through the `MemRd`/`MemWr` strobes the control unit produces. When the low counter overflows, it reloads from the high register and, if enabled, raises `IRQ`. The control unit gates `IRQ` with kernel mode (PC[31]). This block does not see PC[31] and never masks on it.

## Interface
- `PRESCALE`, default 1: count tick period in clock cycles, 1..65536. A value of 1 counts every cycle.
- `BASE`, default 32'h4000_0000: base address of the register window.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset. The block is reset while `reset`=1.
- `addr`  in  32  byte address from ALU result. Bits [1:0] are ignored.
- `wdata`  in  32  store data.
- `MemRd`  in  1  read strobe.
- `MemWr`  in  1  write strobe.
- `rdata`  out  32  read data, combinational.
- `IRQ`  out  1  interrupt request, registered level.

## Operation
- Register map, decoded on `addr[31:2]`:
  - BASE+0: TH, the 32-bit reload value, read/write.
  - BASE+4: TL, the 32-bit counter, read/write.
  - BASE+8: TCON.
- TCON bits:
  - [0] EN, read/write.
  - [1] IE, read/write.
  - [2] ST (status), read/write. A write of 0 clears it. A write of 1 sets it.
  - [31:3] read as 0; writes to them are ignored.
- `IRQ` = IE & ST, taken from the registered bits.
- Tick: with EN=1, a prescale counter runs 0..PRESCALE-1 and emits a one-cycle `tick` on the cycle it wraps to 0. With EN=0 the prescale counter holds its value.
- On `tick`:
  - If TL != 32'hFFFF_FFFF: TL <= TL+1.
  - Else TL <= TH, and ST <= 1 if IE=1.
  - The addition is modulo 2^32. No other flag exists.
- Write (`MemWr`=1, address hit) updates the addressed register at the next edge.
- Priority rules for same-cycle events:
  - A write to TL beats a tick increment or reload of TL.
  - A write to TH takes effect for later reloads. A reload in the same cycle uses the old TH.
  - TCON write vs overflow in the same cycle: EN and IE take the written values. ST becomes 1 if the overflow sets it, regardless of the written value, so an interrupt is never lost.
- Read (`MemRd`=1, hit): `rdata` gives the current register value. With a miss or `MemRd`=0, `rdata`=0.
- Simultaneous `MemRd` and `MemWr`: the read returns the pre-write value.
- Addresses outside BASE..BASE+8: no effect, and reads return 0.

## Timing
- Reset values: TH=0, TL=0, TCON=0, prescale counter=0, `IRQ`=0, `rdata`=0 (strobes low).
- Reset asserted mid-count clears all state immediately. Counting resumes only after EN is written again.
- Write-to-visible latency is 1 cycle: a register written at edge N reads back its new value in cycle N+1.
- With PRESCALE=1, EN=1, TL=FFFF_FFFF: the reload happens at the next edge, and `IRQ` is high in the following cycle (1-cycle latency from the overflow edge).
- From EN going 1 to the first increment: PRESCALE cycles.
- `IRQ` stays high until software clears ST or IE. It is level, not pulse.

## Structure
- Shared package `timer_pkg`:
  - Register offsets `TH_OFF`=0, `TL_OFF`=4, `TCON_OFF`=8.
  - TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_ST`.
  - Default `TIMER_BASE`.
- Sub-module `timer_prescaler`: counter with parameter PRESCALE, input `en`, output `tick`. It is pure sequential and is reused by the future UART baud generator.
- Top module holds the register file, address decode, priority logic and read mux.

## Test plan
- Reset: hold `reset`=1 for 3 cycles, then release. Required: TH, TL, TCON all read 0, `IRQ`=0, `rdata`=0 with strobes low.
- Basic overflow, PRESCALE=1: write TH=FFFF_FFF0, TL=FFFF_FFFE, TCON=3. Required: TL reads FFFF_FFFF, then FFFF_FFF0 after 2 ticks; `IRQ`=1 one cycle after the reload; TCON reads 7.
- Clear and no-IE: write TCON=3 and check `IRQ` drops next cycle. Then write TCON=1 and let TL overflow. Required: TL reloads, ST stays 0, `IRQ` stays 0.
- Collision: ST clear written on the same edge as an overflow. Required: ST=1, `IRQ`=1. TL write on a tick edge: the written value is kept with no increment.
- Prescaler, PRESCALE=4: EN set at edge 0, TL=0. Required: TL=1 at edge 4 and TL=2 at edge 8. Clearing EN freezes TL and the prescale phase.
- Decode: read BASE+C and BASE-4, write BASE+10. Required: reads return 0 and all registers are unchanged. A read of BASE+2 returns TH (low address bits ignored).
